// File: rtl/led_pulser.sv
// Multi-channel LED pulser: a shared prescaled timebase and PWM counter drive
// per-channel periodic on-windows with double-buffered configuration.
module led_pulser #(
    parameter int NUM_CH         = 4,
    parameter int PRESCALE_TICKS = 240,
    parameter int PERIOD_W       = 17,
    parameter int PWM_BITS       = 7,
    parameter int ACTIVE_LOW     = 1,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [PERIOD_W-1:0]   cfg_period,
    input  logic [PERIOD_W-1:0]   cfg_on,
    input  logic [PWM_BITS:0]     cfg_duty,
    output logic [NUM_CH-1:0]     led_out,
    output logic                  tick
);

    localparam int PRE_W = $clog2(PRESCALE_TICKS);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE_TICKS - 1);
    localparam logic POL = (ACTIVE_LOW != 0);

    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;

    logic [PERIOD_W-1:0] pend_period [NUM_CH];
    logic [PERIOD_W-1:0] pend_on     [NUM_CH];
    logic [PWM_BITS:0]   pend_duty   [NUM_CH];
    logic [PERIOD_W-1:0] act_period  [NUM_CH];
    logic [PERIOD_W-1:0] act_on      [NUM_CH];
    logic [PWM_BITS:0]   act_duty    [NUM_CH];
    logic [PERIOD_W-1:0] phase       [NUM_CH];

    logic [NUM_CH-1:0] wr_hit;
    logic [NUM_CH-1:0] wr_disable;
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] lit;

    always_comb begin
        logic in_win;
        wr_hit     = '0;
        wr_disable = '0;
        wrap       = '0;
        lit        = '0;
        in_win     = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            wr_hit[i]     = cfg_we && (cfg_ch == CH_W'(i));
            wr_disable[i] = wr_hit[i] && (cfg_period == '0);
            wrap[i]       = tick && (act_period[i] != '0) &&
                            (phase[i] == act_period[i] - PERIOD_W'(1));
            // period - on is only formed once on < period, so it never wraps
            if (act_on[i] == '0)
                in_win = 1'b0;
            else if (act_on[i] >= act_period[i])
                in_win = 1'b1;
            else
                in_win = (phase[i] >= act_period[i] - act_on[i]);
            lit[i] = (act_period[i] != '0) && in_win &&
                     ({1'b0, pwm_cnt} < act_duty[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
            tick    <= 1'b0;
            led_out <= POL ? '1 : '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                pend_period[i] <= '0;
                pend_on[i]     <= '0;
                pend_duty[i]   <= '0;
                act_period[i]  <= '0;
                act_on[i]      <= '0;
                act_duty[i]    <= '0;
                phase[i]       <= '0;
            end
        end else begin
            tick    <= (pre_cnt == PRE_LAST);
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PRE_W'(1);
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                // a disabling write also blanks the LED in the same edge
                led_out[i] <= (lit[i] && !wr_disable[i]) ^ POL;
                if (wr_hit[i]) begin
                    pend_period[i] <= cfg_period;
                    pend_on[i]     <= cfg_on;
                    pend_duty[i]   <= cfg_duty;
                end
                if (act_period[i] == '0) begin
                    act_period[i] <= pend_period[i];
                    act_on[i]     <= pend_on[i];
                    act_duty[i]   <= pend_duty[i];
                    phase[i]      <= '0;
                end else if (wr_disable[i]) begin
                    act_period[i] <= cfg_period;
                    act_on[i]     <= cfg_on;
                    act_duty[i]   <= cfg_duty;
                    phase[i]      <= '0;
                end else if (wrap[i]) begin
                    act_period[i] <= wr_hit[i] ? cfg_period : pend_period[i];
                    act_on[i]     <= wr_hit[i] ? cfg_on     : pend_on[i];
                    act_duty[i]   <= wr_hit[i] ? cfg_duty   : pend_duty[i];
                    phase[i]      <= '0;
                end else if (tick) begin
                    phase[i] <= phase[i] + PERIOD_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pulser.sv
// Self-checking bench for led_pulser: vector table, directed corner sequences
// and randomized config traffic against a cycle-level reference model.
module tb_led_pulser;

    localparam int NCH  = 3;
    localparam int PRE  = 4;
    localparam int PW   = 17;
    localparam int PB   = 7;
    localparam int NPWM = 1 << PB;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_we;
    logic [1:0]    cfg_ch;
    logic [PW-1:0] cfg_period;
    logic [PW-1:0] cfg_on;
    logic [PB:0]   cfg_duty;
    logic [NCH-1:0] led_out;
    logic          tick;

    int checks = 0;
    int errors = 0;

    led_pulser #(
        .NUM_CH(NCH), .PRESCALE_TICKS(PRE), .PERIOD_W(PW),
        .PWM_BITS(PB), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_on(cfg_on), .cfg_duty(cfg_duty),
        .led_out(led_out), .tick(tick)
    );

    always #5 clk = ~clk;

    // reference model state (plain integers, rules applied per clock)
    int m_pre, m_pwm;
    bit m_tick;
    int pp[NCH], po[NCH], pd[NCH], ap[NCH], ao[NCH], ad[NCH], ph[NCH];
    bit m_led[NCH];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pre = 0; m_pwm = 0; m_tick = 0;
        for (int i = 0; i < NCH; i++) begin
            pp[i] = 0; po[i] = 0; pd[i] = 0; ap[i] = 0; ao[i] = 0; ad[i] = 0;
            ph[i] = 0; m_led[i] = 0;
        end
    endtask

    function automatic bit in_window(input int i);
        if (ao[i] == 0) return 0;
        if (ao[i] >= ap[i]) return 1;
        return ph[i] >= ap[i] - ao[i];
    endfunction

    function automatic logic [NCH-1:0] exp_led();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = ~m_led[i];
        return v;
    endfunction

    // Called at negedge with inputs already driven; returns at next negedge.
    task automatic cycle();
        int n_ap[NCH], n_ao[NCH], n_ad[NCH], n_ph[NCH], n_pp[NCH], n_po[NCH], n_pd[NCH];
        bit n_led[NCH];
        bit wm, lit;
        for (int i = 0; i < NCH; i++) begin
            wm  = cfg_we && (int'(cfg_ch) == i);
            lit = (ap[i] != 0) && in_window(i) && (m_pwm < ad[i]);
            n_led[i] = lit && !(wm && cfg_period == 0);
            n_pp[i] = wm ? int'(cfg_period) : pp[i];
            n_po[i] = wm ? int'(cfg_on)     : po[i];
            n_pd[i] = wm ? int'(cfg_duty)   : pd[i];
            n_ap[i] = ap[i]; n_ao[i] = ao[i]; n_ad[i] = ad[i]; n_ph[i] = ph[i];
            if (ap[i] == 0) begin
                n_ap[i] = pp[i]; n_ao[i] = po[i]; n_ad[i] = pd[i]; n_ph[i] = 0;
            end else if (wm && cfg_period == 0) begin
                n_ap[i] = 0; n_ao[i] = int'(cfg_on); n_ad[i] = int'(cfg_duty); n_ph[i] = 0;
            end else if (m_tick && ph[i] == ap[i] - 1) begin
                n_ap[i] = n_pp[i]; n_ao[i] = n_po[i]; n_ad[i] = n_pd[i]; n_ph[i] = 0;
            end else if (m_tick) begin
                n_ph[i] = ph[i] + 1;
            end
        end
        @(posedge clk);
        m_tick = (m_pre == PRE - 1);
        m_pre  = (m_pre + 1) % PRE;
        m_pwm  = (m_pwm + 1) % NPWM;
        for (int i = 0; i < NCH; i++) begin
            pp[i] = n_pp[i]; po[i] = n_po[i]; pd[i] = n_pd[i];
            ap[i] = n_ap[i]; ao[i] = n_ao[i]; ad[i] = n_ad[i]; ph[i] = n_ph[i];
            m_led[i] = n_led[i];
        end
        #1;
        chk("tick", int'(tick), int'(m_tick));
        chk("led_out", int'(led_out), int'(exp_led()));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        cfg_we = 0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic write(input int ch, input int per, input int on, input int duty);
        cfg_we = 1; cfg_ch = 2'(ch); cfg_period = PW'(per); cfg_on = PW'(on);
        cfg_duty = (PB+1)'(duty);
        cycle();
        cfg_we = 0;
    endtask

    // Reset asserted asynchronously mid-cycle; LEDs must go dark without an edge.
    task automatic do_reset();
        cfg_we = 0; cfg_ch = 0; cfg_period = 0; cfg_on = 0; cfg_duty = 0;
        #2;
        reset = 1;
        #1;
        chk("async_reset_led", int'(led_out), 7);
        chk("async_reset_tick", int'(tick), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        model_reset();
    endtask

    task automatic count_lit(input int ch, input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            cycle();
            if (led_out[ch] == 1'b0) cnt++;
        end
    endtask

    typedef struct {
        int period;
        int on;
        int duty;
        int exp_lit;
    } vec_t;

    vec_t vecs[8];
    int cnt, first_tick, second_tick, guard;

    initial begin
        reset = 1; cfg_we = 0; cfg_ch = 0; cfg_period = 0; cfg_on = 0; cfg_duty = 0;
        model_reset();
        vecs[0] = '{8, 8, 32, 32};
        vecs[1] = '{8, 8, 0, 0};
        vecs[2] = '{8, 8, 128, 128};
        vecs[3] = '{8, 8, 1, 1};
        vecs[4] = '{8, 0, 128, 0};
        vecs[5] = '{8, 20, 64, 64};
        vecs[6] = '{3, 3, 127, 127};
        vecs[7] = '{8, 8, 200, 128};

        repeat (2) @(negedge clk);
        #1;
        chk("reset_led", int'(led_out), 7);
        chk("reset_tick", int'(tick), 0);
        @(negedge clk);
        reset = 0;

        // first tick PRESCALE_TICKS clocks after release, then every PRE
        first_tick = 0; second_tick = 0;
        for (int k = 1; k <= 12; k++) begin
            cfg_we = 0;
            cycle();
            if (tick && first_tick == 0) first_tick = k;
            else if (tick && second_tick == 0) second_tick = k;
        end
        chk("first_tick", first_tick, PRE);
        chk("tick_spacing", second_tick - first_tick, PRE);

        // steady-state brightness over one full PWM cycle on ch1
        for (int v = 0; v < 8; v++) begin
            do_reset();
            write(1, vecs[v].period, vecs[v].on, vecs[v].duty);
            idle(300);
            count_lit(1, NPWM, cnt);
            chk($sformatf("duty_vec%0d", v), cnt, vecs[v].exp_lit);
        end

        // ch0 period 10, on 3: lit 3 of 10 ticks, i.e. 120 of any 400 clocks
        do_reset();
        write(0, 10, 3, 128);
        idle(100);
        count_lit(0, 400, cnt);
        chk("window_10_3", cnt, 120);

        // mid-period rewrite at phase 4: takes effect at the wrap
        guard = 0;
        while (!(ph[0] == 4) && guard < 200) begin idle(1); guard++; end
        chk("reach_phase4", int'(guard < 200), 1);
        write(0, 5, 3, 128);
        chk("old_period_kept", ap[0], 10);
        idle(200);
        count_lit(0, 200, cnt);
        chk("window_5_3", cnt, 120);

        // write in the wrap cycle is used immediately
        guard = 0;
        while (!(m_tick && ph[0] == ap[0] - 1) && guard < 200) begin idle(1); guard++; end
        chk("reach_wrap", int'(guard < 200), 1);
        write(0, 8, 8, 128);
        chk("bypass_period", ap[0], 8);
        idle(1);
        count_lit(0, 32, cnt);
        chk("bypass_lit", cnt, 32);

        // disable while lit, re-enable, out-of-range channel
        write(2, 4, 4, 128);
        idle(20);
        chk("ch2_lit", int'(led_out[2]), 0);
        write(2, 0, 4, 128);
        chk("ch2_off_next", int'(led_out[2]), 1);
        idle(30);
        chk("ch2_stays_off", int'(led_out[2]), 1);
        write(2, 6, 2, 128);
        idle(1);
        chk("ch2_phase_restart", ph[2], 0);
        idle(100);
        do_reset();
        write(3, 2, 2, 128);
        idle(100);
        chk("bad_ch_ignored", int'(led_out), 7);

        // reset mid-window with all channels lit
        for (int c = 0; c < NCH; c++) write(c, 2, 2, 128);
        idle(20);
        chk("all_lit", int'(led_out), 0);
        do_reset();
        idle(200);
        chk("all_off_after_reset", int'(led_out), 7);

        // randomized configuration traffic
        for (int k = 0; k < 5000; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                cfg_we = 1;
                cfg_ch = 2'($urandom_range(0, 3));
                cfg_period = PW'(($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 7));
                cfg_on = PW'($urandom_range(0, 8));
                cfg_duty = (PB+1)'($urandom_range(0, 200));
            end else begin
                cfg_we = 0;
            end
            cycle();
        end
        cfg_we = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/led_pulser.md
LED_PULSER -- requirements
Module: led_pulser

Interface
REQ-001 Parameter NUM_CH, 4, number of independent LED channels (1..16).
REQ-002 Parameter PRESCALE_TICKS, 240, clk cycles per timebase tick (2..65535).
REQ-003 Parameter PERIOD_W, 17, width of per-channel period/on-window counters, in ticks.
REQ-004 Parameter PWM_BITS, 7, width of the shared PWM dimming counter.
REQ-005 Parameter ACTIVE_LOW, 1, 1 = led_out driven low when lit.
REQ-006 clk  input  1  system clock.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 cfg_we  input  1  config write strobe, one write per asserted cycle.
REQ-009 cfg_ch  input  $clog2(NUM_CH) (min 1)  channel addressed by the write.
REQ-010 cfg_period  input  PERIOD_W  period length in ticks; 0 = channel disabled.
REQ-011 cfg_on  input  PERIOD_W  on-window length in ticks, at the end of the period.
REQ-012 cfg_duty  input  PWM_BITS+1  brightness; lit while pwm_cnt < duty.
REQ-013 led_out  output  NUM_CH  registered LED drive, polarity per ACTIVE_LOW.
REQ-014 tick  output  1  one-clk pulse each timebase tick.

Function
REQ-015 Prescaler shall count 0..PRESCALE_TICKS-1 on clk and assert tick for exactly one clk when it wraps to 0.
REQ-016 pwm_cnt (PWM_BITS wide) shall increment every clk and wrap from 2^PWM_BITS-1 to 0, shared by all channels.
REQ-017 Each channel shall hold pending {period,on,duty} registers loaded on cfg_we when cfg_ch matches, and active registers used for output.
REQ-018 Each channel shall have a phase counter that advances only on tick, counting 0..active_period-1 and wrapping to 0.
REQ-019 On a channel's phase wrap (tick with phase = active_period-1), active shall load from pending; a cfg_we to that channel in the same cycle shall be loaded directly (write bypass).
REQ-020 While active_period = 0, the channel shall copy pending to active every clk, hold phase at 0 and remain unlit.
REQ-021 A disabled-to-enabled transition shall start the phase at 0 on the following clk.
REQ-022 Window condition: phase >= active_period - active_on; active_on >= active_period shall mean permanently in window; active_on = 0 shall mean never in window.
REQ-023 lit = window AND (pwm_cnt < active_duty); duty = 0 never lit; duty >= 2^PWM_BITS always lit within the window.
REQ-024 led_out[i] shall be registered: value = lit XOR ACTIVE_LOW, one clk after the phase/pwm_cnt state producing it.
REQ-025 cfg_ch >= NUM_CH writes shall be ignored.
REQ-026 Comparisons shall be unsigned at PERIOD_W bits with no wrap in period - on (compute only when on < period).

Reset
REQ-027 On reset asserted: prescaler, pwm_cnt, all phases = 0; all pending and active registers = 0; tick = 0; led_out = all bits ACTIVE_LOW (LEDs off).
REQ-028 Reset shall take effect immediately, mid-period or mid-write, with no partial config retained.
REQ-029 After reset release, the first tick shall occur PRESCALE_TICKS clks after the first active clk edge.

Verification
REQ-030 PRESCALE_TICKS=4, reset release -> tick pulses every 4 clks, width 1 clk, first at clk 4.
REQ-031 Ch0 write period=10, on=3, duty=2^PWM_BITS -> led_out[0] lit exactly during phases 7..9 of every period, unlit 0..6, 1-clk registered latency.
REQ-032 Ch1 period=8, on=8, duty=32 (PWM_BITS=7) -> lit 32 of every 128 clks continuously; duty=0 -> never lit.
REQ-033 Ch0 running with period=10, rewrite period=5 mid-period (phase 4) -> old period completes to phase 9, new 5-tick period starts at the wrap; write in the wrap cycle -> new value used immediately.
REQ-034 Write period=0 to ch2 while lit -> led_out[2] off next clk; write period=6 later -> phase restarts at 0; cfg_ch=NUM_CH write -> no channel changes.
REQ-035 Assert reset mid-window with all channels lit -> led_out all off (ACTIVE_LOW level) asynchronously, all config cleared, no LED lit until rewritten.
